regfile_scoreboard: RTL and testbench

Tracks in-flight register writes for the pipelined processor's 32x32 register file. Decode presents each instruction's sources and destination. The block raises a stall while any source has an uncommitted write pending. It commits a pending write when writeback asserts the register file write port. The block sits between the decode stage and the register file write enable; it is the hazard sequencer for that resource.

---
 rtl/regfile_scoreboard_pkg.sv | 17 +
 rtl/regfile_scoreboard_sb_counter.sv | 44 ++++
 rtl/regfile_scoreboard.sv | 96 +++++++++
 tb/tb_regfile_scoreboard.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/regfile_scoreboard_pkg.sv
// Shared constants and types for the register-file scoreboard.
// Imported by the pending counter and the top level.
package regfile_scoreboard_pkg;

    localparam int NUM_REGS     = 32;
    localparam int ADDR_W       = 5;
    localparam int MAX_INFLIGHT = 3;
    localparam int CNT_W        = 2;
    localparam int STALL_CNT_W  = 16;

    localparam logic [ADDR_W-1:0] ZERO_REG = '0;

    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t CNT_MAX = cnt_t'(MAX_INFLIGHT);

endpackage

// File: rtl/regfile_scoreboard_sb_counter.sv
// Per-register pending-write counter with clear.
// Saturates at CNT_MAX going up and at zero going down.
module sb_counter
    import regfile_scoreboard_pkg::*;
(
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic inc_i,
    input  logic dec_i,
    output cnt_t cnt_o,
    output logic busy_o
);

    cnt_t cnt_q, cnt_d;
    logic busy_q;

    // Next count: clear wins, paired inc/dec cancel.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && !dec_i && cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end else if (dec_i && !inc_i && cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Count and busy flag, busy taken from the next count.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            busy_q <= (cnt_d != '0);
        end
    end

    assign cnt_o  = cnt_q;
    assign busy_o = busy_q;

endmodule

// File: rtl/regfile_scoreboard.sv
// Register-file scoreboard: tracks in-flight writes and
// stalls decode on RAW hazards or tracker overflow.
module regfile_scoreboard
    import regfile_scoreboard_pkg::*;
(
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   issue_valid,
    input  logic [ADDR_W-1:0]      issue_src1,
    input  logic                   issue_src1_en,
    input  logic [ADDR_W-1:0]      issue_src2,
    input  logic                   issue_src2_en,
    input  logic [ADDR_W-1:0]      issue_rd,
    input  logic                   issue_rd_en,
    input  logic                   wb_valid,
    input  logic [ADDR_W-1:0]      wb_rd,
    input  logic                   flush,
    output logic                   stall,
    output logic                   issue_accept,
    output logic [NUM_REGS-1:0]    busy,
    output logic [STALL_CNT_W-1:0] stall_cycles,
    output logic                   underflow_err
);

    cnt_t                  cnt [NUM_REGS];
    cnt_t                  eff [NUM_REGS];
    logic [NUM_REGS-1:1]   inc_v;
    logic [NUM_REGS-1:1]   dec_v;
    logic                  h1, h2, ho;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic                  uflow_q, uflow_d;

    assign cnt[0]  = '0;
    assign busy[0] = 1'b0;

    // Per-register increment/decrement and effective counts.
    always_comb begin
        eff[0] = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            dec_v[r] = wb_valid && (wb_rd == ADDR_W'(r))
                       && (cnt[r] != '0);
            inc_v[r] = issue_accept && issue_rd_en
                       && (issue_rd == ADDR_W'(r));
            eff[r]   = cnt[r] - cnt_t'(dec_v[r]);
        end
    end

    // Hazard decision, same cycle as the issue.
    always_comb begin
        h1 = issue_src1_en && (eff[issue_src1] != '0);
        h2 = issue_src2_en && (eff[issue_src2] != '0);
        ho = issue_rd_en && (eff[issue_rd] == CNT_MAX);
        stall = issue_valid && !flush && (h1 || h2 || ho);
        issue_accept = issue_valid && !stall && !flush;
    end

    for (genvar r = 1; r < NUM_REGS; r++) begin : g_cnt
        sb_counter u_cnt (
            .clk_i  (clock),
            .rst_ni (reset),
            .clr_i  (flush),
            .inc_i  (inc_v[r]),
            .dec_i  (dec_v[r]),
            .cnt_o  (cnt[r]),
            .busy_o (busy[r])
        );
    end

    // Saturating stall counter and sticky underflow next-state.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        uflow_d = uflow_q;
        if (wb_valid && !flush && wb_rd != ZERO_REG
            && cnt[wb_rd] == '0) begin
            uflow_d = 1'b1;
        end
    end

    // Stall counter and underflow flag registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
            uflow_q     <= 1'b0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            uflow_q     <= uflow_d;
        end
    end

    assign stall_cycles  = stall_cnt_q;
    assign underflow_err = uflow_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard.
// Hand-computed expectations checked with immediate asserts.
module tb_regfile_scoreboard;

    logic        clock = 1'b0;
    logic        reset;
    logic        issue_valid;
    logic [4:0]  issue_src1;
    logic        issue_src1_en;
    logic [4:0]  issue_src2;
    logic        issue_src2_en;
    logic [4:0]  issue_rd;
    logic        issue_rd_en;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        flush;
    logic        stall;
    logic        issue_accept;
    logic [31:0] busy;
    logic [15:0] stall_cycles;
    logic        underflow_err;

    int tests = 0;
    int fails = 0;

    regfile_scoreboard dut (
        .clock         (clock),
        .reset         (reset),
        .issue_valid   (issue_valid),
        .issue_src1    (issue_src1),
        .issue_src1_en (issue_src1_en),
        .issue_src2    (issue_src2),
        .issue_src2_en (issue_src2_en),
        .issue_rd      (issue_rd),
        .issue_rd_en   (issue_rd_en),
        .wb_valid      (wb_valid),
        .wb_rd         (wb_rd),
        .flush         (flush),
        .stall         (stall),
        .issue_accept  (issue_accept),
        .busy          (busy),
        .stall_cycles  (stall_cycles),
        .underflow_err (underflow_err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic idle();
        issue_valid   = 0;
        issue_src1    = 0;
        issue_src1_en = 0;
        issue_src2    = 0;
        issue_src2_en = 0;
        issue_rd      = 0;
        issue_rd_en   = 0;
        wb_valid      = 0;
        wb_rd         = 0;
        flush         = 0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic iss_rd(input logic [4:0] rd);
        idle();
        issue_valid = 1;
        issue_rd    = rd;
        issue_rd_en = 1;
    endtask

    task automatic wb(input logic [4:0] rd);
        idle();
        wb_valid = 1;
        wb_rd    = rd;
    endtask

    initial begin
        idle();
        reset = 0;
        tick();
        tick();
        chk("rst_busy", busy, 32'h0);
        chk("rst_sc", 32'(stall_cycles), 32'h0);
        chk("rst_uf", 32'(underflow_err), 32'h0);
        reset = 1;
        tick();

        // 1: RAW hazard and same-cycle writeback bypass
        iss_rd(5);
        #1;
        chk("t1_acc_rd5", 32'(issue_accept), 32'h1);
        tick();
        chk("t1_busy5", busy, 32'h20);
        idle();
        issue_valid   = 1;
        issue_src1    = 5;
        issue_src1_en = 1;
        #1;
        chk("t1_stall", 32'(stall), 32'h1);
        chk("t1_nacc", 32'(issue_accept), 32'h0);
        wb_valid = 1;
        wb_rd    = 5;
        #1;
        chk("t1_bypass_stall", 32'(stall), 32'h0);
        chk("t1_bypass_acc", 32'(issue_accept), 32'h1);
        tick();
        chk("t1_busy_clr", busy, 32'h0);
        chk("t1_sc", 32'(stall_cycles), 32'h0);

        // 2: r0 never tracked
        iss_rd(0);
        issue_src1    = 0;
        issue_src1_en = 1;
        issue_src2    = 0;
        issue_src2_en = 1;
        #1;
        chk("t2_stall", 32'(stall), 32'h0);
        tick();
        #1;
        chk("t2_stall2", 32'(stall), 32'h0);
        chk("t2_busy", busy, 32'h0);

        // 3: overflow hazard at three in flight
        iss_rd(7);
        tick();
        tick();
        tick();
        chk("t3_busy7", busy, 32'h80);
        #1;
        chk("t3_ho_stall", 32'(stall), 32'h1);
        tick();
        chk("t3_sc1", 32'(stall_cycles), 32'h1);
        chk("t3_still_full", 32'(stall), 32'h1);
        wb(7);
        tick();
        chk("t3_wb1", busy, 32'h80);
        tick();
        chk("t3_wb2", busy, 32'h80);
        tick();
        chk("t3_wb3", busy, 32'h0);
        chk("t3_uf", 32'(underflow_err), 32'h0);

        // 4: underflow is sticky, count stays at zero
        wb(9);
        tick();
        chk("t4_uf", 32'(underflow_err), 32'h1);
        chk("t4_busy", busy, 32'h0);
        iss_rd(9);
        tick();
        chk("t4_busy9", busy, 32'h200);
        wb(9);
        tick();
        chk("t4_busy9_clr", busy, 32'h0);
        idle();
        tick();
        chk("t4_uf_sticky", 32'(underflow_err), 32'h1);

        // 5: flush clears tracking
        iss_rd(3);
        tick();
        iss_rd(4);
        tick();
        iss_rd(12);
        tick();
        chk("t5_busy", busy, 32'h1018);
        iss_rd(3);
        flush = 1;
        #1;
        chk("t5_flush_acc", 32'(issue_accept), 32'h0);
        chk("t5_flush_stall", 32'(stall), 32'h0);
        tick();
        chk("t5_busy_clr", busy, 32'h0);

        // 6: stall counter saturation then async reset
        iss_rd(20);
        tick();
        idle();
        issue_valid   = 1;
        issue_src1    = 20;
        issue_src1_en = 1;
        #1;
        chk("t6_stall", 32'(stall), 32'h1);
        repeat (70000) @(posedge clock);
        #1;
        chk("t6_sat", 32'(stall_cycles), 32'hFFFF);
        tick();
        chk("t6_sat_hold", 32'(stall_cycles), 32'hFFFF);
        #2;
        reset = 0;
        #1;
        chk("t6_ar_busy", busy, 32'h0);
        chk("t6_ar_sc", 32'(stall_cycles), 32'h0);
        chk("t6_ar_uf", 32'(underflow_err), 32'h0);
        chk("t6_ar_stall", 32'(stall), 32'h0);
        tick();
        reset = 1;
        #1;
        chk("t6_post_stall", 32'(stall), 32'h0);
        chk("t6_post_acc", 32'(issue_accept), 32'h1);
        idle();
        tick();
        chk("t6_post_busy", busy, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
